// File: rtl/fullxor_sched.sv
// Arbitrates masked operands onto a shared full-XOR datapath.
// Gathers fresh randomness per operation and scrubs shares afterwards.
module fullxor_sched #(
    parameter int K_WIDTH   = 32,
    parameter int N_SHARES  = 5,
    parameter int RANDNUM   = 5,
    parameter int N_REQ     = 2,
    parameter int TIMEOUT   = 7,
    parameter int MASKWIDTH = K_WIDTH * N_SHARES,
    parameter int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_REQ-1:0]             req_vld_i,
    output logic [N_REQ-1:0]             req_rdy_o,
    input  logic [N_REQ*MASKWIDTH-1:0]   req_x_i,
    input  logic                         rnd_vld_i,
    output logic                         rnd_rdy_o,
    input  logic [K_WIDTH-1:0]           rnd_i,
    output logic                         dp_dvld_o,
    output logic                         dp_ena_o,
    output logic [MASKWIDTH-1:0]         dp_x_o,
    output logic [K_WIDTH*RANDNUM-1:0]   dp_rnd_o,
    input  logic [K_WIDTH-1:0]           dp_z_i,
    input  logic                         dp_ovld_i,
    output logic                         rsp_vld_o,
    input  logic                         rsp_rdy_i,
    output logic [K_WIDTH-1:0]           rsp_z_o,
    output logic [ID_W-1:0]              rsp_id_o,
    output logic                         busy_o,
    output logic                         err_o
);

    localparam int CNT_MAX = (RANDNUM > TIMEOUT) ? RANDNUM : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RNDW    = K_WIDTH * RANDNUM;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GATHER,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      id_buf;
    logic [ID_W-1:0]      gnt_id;
    logic                 gnt_vld;
    logic [CNT_W-1:0]     cnt;
    logic [MASKWIDTH-1:0] x_buf;
    logic [RNDW-1:0]      rnd_buf;
    logic [K_WIDTH-1:0]   rsp_z;
    logic                 err;
    logic                 last_rnd;
    logic                 timed_out;

    function automatic logic [ID_W-1:0] wrap(input int v);
        return ID_W'(v % N_REQ);
    endfunction

    // Lowest offset from ptr wins, so scan downwards and let it overwrite.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_vld_i[wrap(int'(ptr) + k)]) begin
                gnt_vld = 1'b1;
                gnt_id  = wrap(int'(ptr) + k);
            end
        end
    end

    assign last_rnd  = (cnt == CNT_W'(RANDNUM - 1));
    assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nxt = state;
        req_rdy_o = '0;
        rnd_rdy_o = 1'b0;
        dp_dvld_o = 1'b0;
        dp_ena_o  = 1'b0;
        rsp_vld_o = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (gnt_vld) begin
                    req_rdy_o[gnt_id] = 1'b1;
                    state_nxt         = S_GATHER;
                end
            end
            S_GATHER: begin
                rnd_rdy_o = 1'b1;
                if (rnd_vld_i && last_rnd) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                dp_dvld_o = 1'b1;
                dp_ena_o  = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                dp_ena_o = 1'b1;
                if (dp_ovld_i)      state_nxt = S_RESP;
                else if (timed_out) state_nxt = S_IDLE;
            end
            S_RESP: begin
                rsp_vld_o = 1'b1;
                if (rsp_rdy_i) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            ptr     <= '0;
            cnt     <= '0;
            x_buf   <= '0;
            rnd_buf <= '0;
            id_buf  <= '0;
            rsp_z   <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nxt;
            unique case (state)
                S_IDLE: begin
                    if (gnt_vld) begin
                        x_buf  <= req_x_i[int'(gnt_id)*MASKWIDTH +: MASKWIDTH];
                        id_buf <= gnt_id;
                        ptr    <= wrap(int'(gnt_id) + 1);
                        cnt    <= '0;
                    end
                end
                S_GATHER: begin
                    if (rnd_vld_i) begin
                        rnd_buf[int'(cnt)*K_WIDTH +: K_WIDTH] <= rnd_i;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_ISSUE: cnt <= '0;
                S_WAIT: begin
                    // Either exit wipes shares and mask material.
                    if (dp_ovld_i || timed_out) begin
                        x_buf   <= '0;
                        rnd_buf <= '0;
                        cnt     <= '0;
                        if (dp_ovld_i) rsp_z <= dp_z_i;
                        else           err   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign dp_x_o   = x_buf;
    assign dp_rnd_o = rnd_buf;
    assign rsp_z_o  = rsp_z;
    assign rsp_id_o = id_buf;
    assign busy_o   = (state != S_IDLE);
    assign err_o    = err;

endmodule

// File: tb/tb_fullxor_sched.sv
// Scoreboard bench for fullxor_sched: random traffic plus
// directed latency, fairness, stall, backpressure, timeout, reset.
module tb_fullxor_sched;

    localparam int K   = 32;
    localparam int NS  = 5;
    localparam int RN  = 5;
    localparam int NR  = 2;
    localparam int TO  = 7;
    localparam int MW  = K * NS;
    localparam int IDW = 1;
    localparam int RW  = K * RN;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_i;
    logic [NR-1:0]     req_vld_i;
    logic [NR-1:0]     req_rdy_o;
    logic [NR*MW-1:0]  req_x_i;
    logic              rnd_vld_i;
    logic              rnd_rdy_o;
    logic [K-1:0]      rnd_i;
    logic              dp_dvld_o;
    logic              dp_ena_o;
    logic [MW-1:0]     dp_x_o;
    logic [RW-1:0]     dp_rnd_o;
    logic [K-1:0]      dp_z_i;
    logic              dp_ovld_i;
    logic              rsp_vld_o;
    logic              rsp_rdy_i;
    logic [K-1:0]      rsp_z_o;
    logic [IDW-1:0]    rsp_id_o;
    logic              busy_o;
    logic              err_o;

    fullxor_sched #(
        .K_WIDTH(K), .N_SHARES(NS), .RANDNUM(RN),
        .N_REQ(NR), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_x_i(req_x_i),
        .rnd_vld_i(rnd_vld_i), .rnd_rdy_o(rnd_rdy_o), .rnd_i(rnd_i),
        .dp_dvld_o(dp_dvld_o), .dp_ena_o(dp_ena_o), .dp_x_o(dp_x_o),
        .dp_rnd_o(dp_rnd_o), .dp_z_i(dp_z_i), .dp_ovld_i(dp_ovld_i),
        .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy_i), .rsp_z_o(rsp_z_o),
        .rsp_id_o(rsp_id_o), .busy_o(busy_o), .err_o(err_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [K-1:0] fold(input logic [MW-1:0] x);
        logic [K-1:0] r;
        r = '0;
        for (int s = 0; s < NS; s++) r ^= x[s*K +: K];
        return r;
    endfunction

    function automatic logic [MW-1:0] rand_x();
        logic [MW-1:0] r;
        for (int s = 0; s < NS; s++) r[s*K +: K] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] outs();
        return 512'({req_rdy_o, rnd_rdy_o, dp_dvld_o, dp_ena_o, dp_x_o,
                     dp_rnd_o, rsp_vld_o, rsp_z_o, rsp_id_o, busy_o, err_o});
    endfunction

    // Environment knobs written by the main sequence.
    bit rnd_block = 0, rnd_rand = 0;
    bit rsp_block = 0, rsp_rand = 0;
    bit dp_hang = 0, lat_rand = 0;

    // Randomness source: counting words 1,2,3.. after reset.
    int rnd_ctr;
    initial begin
        rnd_vld_i = 1'b0;
        rnd_i     = '0;
        rnd_ctr   = 1;
        forever begin
            @(negedge clk); #1;
            rnd_vld_i = !rnd_block && (!rnd_rand || $urandom_range(0, 3) != 0);
            rnd_i     = rnd_rand ? K'($urandom) : K'(rnd_ctr);
            if (rst_i) rnd_ctr = 1;
            else if (rnd_vld_i && rnd_rdy_o) rnd_ctr++;
        end
    end

    initial begin
        rsp_rdy_i = 1'b0;
        forever begin
            @(negedge clk); #1;
            rsp_rdy_i = !rsp_block && (!rsp_rand || $urandom_range(0, 1) == 1);
        end
    end

    // Datapath model: unmasked result is the XOR of all shares.
    logic [K-1:0] dp_res;
    int           dp_lat;
    initial begin
        dp_ovld_i = 1'b0;
        dp_z_i    = '0;
        forever begin
            @(negedge clk); #1;
            dp_z_i = $urandom;
            if (dp_dvld_o && !rst_i && !dp_hang) begin
                dp_res = fold(dp_x_o);
                dp_lat = lat_rand ? $urandom_range(0, 4) : 0;
                @(negedge clk); #1;
                repeat (dp_lat) begin @(negedge clk); #1; end
                dp_ovld_i = 1'b1;
                dp_z_i    = dp_res;
                @(negedge clk); #1;
                dp_ovld_i = 1'b0;
                dp_z_i    = $urandom;
            end
        end
    end

    // Scoreboard monitor.
    logic [K+IDW-1:0] exp_q[$];
    logic [K-1:0]     rnd_q[$];
    logic [MW-1:0]    cur_x, held_x;
    logic [RW-1:0]    held_rnd, exp_rnd;
    logic [K+IDW-1:0] held_rsp, exp_e;
    bit               in_wait = 0, rsp_hold = 0;
    int               rr_start = 0, mg;

    initial begin
        forever begin
            @(negedge clk); #2;
            if (rst_i) begin
                exp_q.delete();
                rnd_q.delete();
                rr_start = 0;
                in_wait  = 0;
                rsp_hold = 0;
            end else begin
                if (|req_rdy_o) begin
                    mg = 0;
                    for (int k = NR - 1; k >= 0; k--)
                        if (req_vld_i[(rr_start + k) % NR]) mg = (rr_start + k) % NR;
                    chk("rr_grant", 512'(req_rdy_o), 512'(1 << mg));
                    chk("rdy_only_idle", 512'(busy_o), 512'(0));
                    cur_x = req_x_i[mg*MW +: MW];
                    exp_q.push_back({IDW'(mg), fold(cur_x)});
                    rr_start = (mg + 1) % NR;
                end else if (busy_o && |req_vld_i) begin
                    chk("rdy_busy", 512'(req_rdy_o), 512'(0));
                end
                if (rnd_vld_i && rnd_rdy_o) rnd_q.push_back(rnd_i);
                if (dp_dvld_o) begin
                    exp_rnd = '0;
                    for (int j = 0; j < RN; j++)
                        if (j < rnd_q.size()) exp_rnd[j*K +: K] = rnd_q[j];
                    chk("rnd_count", 512'(rnd_q.size()), 512'(RN));
                    chk("issue_x", 512'(dp_x_o), 512'(cur_x));
                    chk("issue_rnd", 512'(dp_rnd_o), 512'(exp_rnd));
                    chk("issue_ena", 512'(dp_ena_o), 512'(1));
                    rnd_q.delete();
                    held_x   = dp_x_o;
                    held_rnd = dp_rnd_o;
                    in_wait  = 1;
                end else if (in_wait) begin
                    if (dp_ena_o) begin
                        chk("dp_hold", 512'({dp_x_o, dp_rnd_o}),
                            512'({held_x, held_rnd}));
                    end else begin
                        chk("scrub", 512'({dp_x_o, dp_rnd_o}), 512'(0));
                        in_wait = 0;
                    end
                end
                if (rsp_vld_o) begin
                    if (rsp_hold)
                        chk("rsp_stable", 512'({rsp_z_o, rsp_id_o}), 512'(held_rsp));
                    if (rsp_rdy_i) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL rsp_unexpected: got id %0d expected no response",
                                     rsp_id_o);
                        end else begin
                            exp_e = exp_q.pop_front();
                            chk("rsp_id", 512'(rsp_id_o), 512'(exp_e[K+IDW-1:K]));
                            chk("rsp_z", 512'(rsp_z_o), 512'(exp_e[K-1:0]));
                        end
                        rsp_hold = 0;
                    end else begin
                        rsp_hold = 1;
                        held_rsp = {rsp_z_o, rsp_id_o};
                    end
                end
            end
        end
    end

    // Call at a negedge; samples each cycle at +3; returns at +3 on a hit.
    task automatic wait_sig(input int which, input int maxc, output int cyc);
        bit hit;
        cyc = -1;
        for (int c = 0; c < maxc; c++) begin
            #3;
            case (which)
                0:       hit = |req_rdy_o;
                1:       hit = dp_dvld_o;
                2:       hit = rsp_vld_o;
                default: hit = !busy_o;
            endcase
            if (hit) begin
                cyc = c;
                break;
            end
            @(negedge clk);
        end
        if (cyc < 0) begin
            checks++;
            failures++;
            $display("FAIL wait_%0d: got timeout after %0d cycles expected event",
                     which, maxc);
        end
    endtask

    task automatic settle();
        int c;
        @(negedge clk);
        wait_sig(3, 200, c);
        @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int            c, waits;
        bit            rsp_seen;
        logic [RW-1:0] w15;
        logic [511:0]  hold;
        bit [NR-1:0]   gprev;
        int            ops;

        rst_i     = 1'b1;
        req_vld_i = '0;
        req_x_i   = '0;
        repeat (3) @(negedge clk);
        #3;
        chk("reset_outs", outs(), 512'(0));
        @(negedge clk);
        rst_i = 1'b0;

        // Single request, minimum latency.
        req_x_i[0 +: MW] = {NS{32'h11111111}};
        req_vld_i        = 2'b01;
        wait_sig(0, 20, c);
        chk("t1_grant", 512'(req_rdy_o), 512'(2'b01));
        @(negedge clk);
        req_vld_i = '0;
        wait_sig(1, 20, c);
        chk("t1_issue_cycle", 512'(c + 1), 512'(6));
        for (int j = 0; j < RN; j++) w15[j*K +: K] = K'(j + 1);
        chk("t1_rnd_words", 512'(dp_rnd_o), 512'(w15));
        @(negedge clk);
        wait_sig(2, 20, c);
        chk("t1_rsp_cycle", 512'(c + 7), 512'(8));
        chk("t1_rsp", 512'({rsp_z_o, rsp_id_o}), 512'({32'h11111111, 1'b0}));
        settle();

        // Fairness after reset: both held valid.
        rst_i = 1'b1;
        @(negedge clk);
        rst_i     = 1'b0;
        req_x_i   = {rand_x(), rand_x()};
        req_vld_i = 2'b11;
        for (int n = 0; n < 4; n++) begin
            wait_sig(0, 100, c);
            if (c < 0) break;
            chk("fair_order", 512'(req_rdy_o), 512'(1 << (n % 2)));
            @(negedge clk);
            req_x_i[(n % 2)*MW +: MW] = rand_x();
        end
        req_vld_i = '0;
        settle();

        // Randomness stall of 3 cycles after word 2.
        req_x_i[0 +: MW] = rand_x();
        req_vld_i        = 2'b01;
        wait_sig(0, 20, c);
        @(negedge clk);
        req_vld_i = '0;
        @(negedge clk);
        @(negedge clk);
        rnd_block = 1;
        repeat (3) @(negedge clk);
        rnd_block = 0;
        wait_sig(1, 20, c);
        chk("stall_issue_cycle", 512'(c + 6), 512'(9));
        settle();

        // Response backpressure with requester 0 pending.
        rsp_block         = 1;
        req_x_i[MW +: MW] = rand_x();
        req_vld_i         = 2'b10;
        wait_sig(0, 20, c);
        @(negedge clk);
        req_x_i[0 +: MW] = rand_x();
        req_vld_i        = 2'b01;
        wait_sig(2, 30, c);
        hold = 512'({rsp_vld_o, rsp_z_o, rsp_id_o});
        chk("bp_id", 512'(rsp_id_o), 512'(1));
        chk("bp_z", 512'(rsp_z_o), 512'(fold(req_x_i[MW +: MW])));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #3;
            chk("bp_stable", 512'({rsp_vld_o, rsp_z_o, rsp_id_o}), hold);
            chk("bp_no_rdy", 512'(req_rdy_o), 512'(0));
        end
        @(negedge clk);
        rsp_block = 0;
        wait_sig(0, 20, c);
        chk("bp_next_grant", 512'(req_rdy_o), 512'(2'b01));
        @(negedge clk);
        req_vld_i = '0;
        settle();

        // Timeout: datapath never answers.
        dp_hang          = 1;
        req_x_i[0 +: MW] = rand_x();
        req_vld_i        = 2'b01;
        wait_sig(0, 20, c);
        @(negedge clk);
        req_vld_i = '0;
        wait_sig(1, 20, c);
        chk("to_err_before", 512'(err_o), 512'(0));
        waits    = 0;
        rsp_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #3;
            if (!busy_o) break;
            if (dp_ena_o && !dp_dvld_o) waits++;
            if (rsp_vld_o) rsp_seen = 1;
        end
        chk("to_wait_cycles", 512'(waits), 512'(TO));
        chk("to_err", 512'(err_o), 512'(1));
        chk("to_no_rsp", 512'(rsp_seen), 512'(0));
        chk("to_scrub", 512'({dp_x_o, dp_rnd_o}), 512'(0));
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        dp_hang = 0;
        @(negedge clk);
        req_x_i[MW +: MW] = rand_x();
        req_vld_i         = 2'b10;
        wait_sig(0, 20, c);
        @(negedge clk);
        req_vld_i = '0;
        wait_sig(2, 30, c);
        chk("to_next_id", 512'(rsp_id_o), 512'(1));
        settle();

        // Random traffic.
        rnd_rand = 1;
        rsp_rand = 1;
        lat_rand = 1;
        gprev    = '0;
        ops      = 0;
        for (int cy = 0; cy < 3000 && ops < 40; cy++) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (gprev[i]) begin
                    if ($urandom_range(0, 1) == 1) req_vld_i[i] = 1'b0;
                    else req_x_i[i*MW +: MW] = rand_x();
                end else if (!req_vld_i[i] && $urandom_range(0, 2) == 0) begin
                    req_vld_i[i]         = 1'b1;
                    req_x_i[i*MW +: MW]  = rand_x();
                end
            end
            #3;
            gprev = req_rdy_o;
            if (|req_rdy_o) ops++;
        end
        @(negedge clk);
        req_vld_i = '0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #3;
            if (exp_q.size() == 0 && !busy_o) break;
        end
        chk("rand_ops", 512'(ops >= 40), 512'(1));
        chk("rand_drain", 512'(exp_q.size()), 512'(0));
        rnd_rand = 0;
        rsp_rand = 0;
        lat_rand = 0;
        settle();

        // Reset in the middle of WAIT.
        dp_hang          = 1;
        req_x_i[0 +: MW] = rand_x();
        req_vld_i        = 2'b01;
        wait_sig(0, 20, c);
        @(negedge clk);
        req_vld_i = '0;
        wait_sig(1, 20, c);
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        #3;
        chk("rst_wait_outs", outs(), 512'(0));
        @(negedge clk);
        dp_hang   = 0;
        req_x_i   = {rand_x(), rand_x()};
        req_vld_i = 2'b11;
        wait_sig(0, 20, c);
        chk("rst_ptr_grant", 512'(req_rdy_o), 512'(2'b01));
        @(negedge clk);
        req_vld_i = 2'b10;
        wait_sig(0, 30, c);
        chk("rst_second_grant", 512'(req_rdy_o), 512'(2'b10));
        @(negedge clk);
        req_vld_i = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #3;
            if (exp_q.size() == 0 && !busy_o) break;
        end
        chk("final_drain", 512'(exp_q.size()), 512'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fullxor_sched.md
FULLXOR_SCHED -- requirements
Module: fullxor_sched

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- K_WIDTH, 32, share/word width
- N_SHARES, 5, shares per masked operand
- RANDNUM, 5, random words consumed per datapath operation
- N_REQ, 2, number of requesters
- TIMEOUT, 7, maximum WAIT cycles before abort
- MASKWIDTH, K_WIDTH*N_SHARES, masked operand width
- ID_W, max(1,clog2(N_REQ)), requester index width
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_i  in  1  sole clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- req_vld_i  in  N_REQ  per-requester request valid
- req_rdy_o  out  N_REQ  per-requester request accept
- req_x_i  in  N_REQ*MASKWIDTH  masked operands; requester i at slice i*MASKWIDTH
- rnd_vld_i  in  1  random word valid
- rnd_rdy_o  out  1  random word accept
- rnd_i  in  K_WIDTH  fresh random word
- dp_dvld_o  out  1  datapath input valid
- dp_ena_o  out  1  datapath enable
- dp_x_o  out  MASKWIDTH  datapath masked operand
- dp_rnd_o  out  K_WIDTH*RANDNUM  datapath randomness; word j at slice j*K_WIDTH
- dp_z_i  in  K_WIDTH  datapath unmasked result
- dp_ovld_i  in  1  datapath output valid
- rsp_vld_o  out  1  response valid
- rsp_rdy_i  in  1  response accept
- rsp_z_o  out  K_WIDTH  unmasked result
- rsp_id_o  out  ID_W  index of the requester served
- busy_o  out  1  high in every state except IDLE
- err_o  out  1  sticky timeout flag

Function
REQ-003 The FSM SHALL have states IDLE, GATHER, ISSUE, WAIT and RESP; all sequential logic SHALL use clk_i only.
REQ-004 In IDLE the block SHALL grant round-robin: the first i with req_vld_i[i]=1, searching from pointer ptr upward with wrap-around.
REQ-005 req_rdy_o[i] SHALL be 1 only in IDLE and only for the granted i (combinational); it SHALL be 0 in all other states.
REQ-006 On a grant the block SHALL capture req_x_i slice i into x_buf, store i in id_buf, set ptr=(i+1) mod N_REQ, clear cnt, and enter GATHER.
REQ-007 In GATHER rnd_rdy_o SHALL be 1; each rnd_vld_i&rnd_rdy_o cycle SHALL store rnd_i into word cnt of rnd_buf and increment cnt.
REQ-008 When rnd_vld_i=0 in GATHER, cnt and rnd_buf SHALL hold.
REQ-009 On acceptance of word RANDNUM-1 the block SHALL enter ISSUE; rnd_rdy_o SHALL be 0 outside GATHER.
REQ-010 Each random word SHALL be used for exactly one operation and never reused.
REQ-011 ISSUE SHALL last exactly one cycle with dp_dvld_o=1 and dp_ena_o=1, then go to WAIT with cnt cleared.
REQ-012 In WAIT: dp_dvld_o=0 and dp_ena_o=1; in IDLE, GATHER and RESP, dp_ena_o=0.
REQ-013 dp_x_o=x_buf and dp_rnd_o=rnd_buf SHALL be held stable from ISSUE through the last WAIT cycle.
REQ-014 In WAIT, dp_ovld_i=1 SHALL load dp_z_i into rsp_z_o and enter RESP.
REQ-015 In WAIT, if dp_ovld_i is still 0 after TIMEOUT WAIT cycles, the block SHALL set err_o=1 and return to IDLE without producing a response.
REQ-016 On leaving WAIT by either path, x_buf and rnd_buf SHALL be cleared to 0 so that no shares or mask material is retained.
REQ-017 In RESP: rsp_vld_o=1 and rsp_id_o=id_buf; these and rsp_z_o SHALL be held stable until rsp_rdy_i=1, then the block SHALL return to IDLE.
REQ-018 The first new grant SHALL come no earlier than the IDLE cycle that follows RESP.
REQ-019 Minimum latency: request handshake at cycle T, no stalls -> GATHER T+1..T+RANDNUM, ISSUE T+RANDNUM+1, rsp_vld_o=1 at T+RANDNUM+3 (T+8 with defaults).
REQ-020 Requests that arrive while the block is busy SHALL receive no req_rdy_o and SHALL be neither lost nor reordered; each requester's own handshake protects it.

Reset
REQ-021 rst_i=1 at a clock edge SHALL force, regardless of state (including mid-GATHER or mid-WAIT):
- state=IDLE, ptr=0, cnt=0, err_o=0
- x_buf, rnd_buf, id_buf and rsp_z_o cleared to 0
- all outputs 0 in the next cycle
REQ-022 The synchronous reset SHALL take priority over every other transition.

Verification
REQ-023 Single request: req 0, x with all shares 0x11111111, rnd words 1..5 with no stalls -> one dvld pulse at T+6; dp_z_i=0x11111111 returned; rsp_vld_o at T+8 with rsp_id_o=0.
REQ-024 Fairness: both requesters held valid for 4 operations -> service order 0,1,0,1; req_rdy_o is one-hot and only in IDLE.
REQ-025 Randomness stall: rnd_vld_i low for 3 cycles after word 2 -> cnt holds; ISSUE delayed 3 cycles; dp_rnd_o equals the 5 accepted words in order.
REQ-026 Response backpressure: rsp_rdy_i low for 4 cycles -> rsp_vld_o, rsp_z_o and rsp_id_o stable; req_rdy_o stays 0.
REQ-027 Timeout: dp_ovld_i held 0 -> err_o=1 after 7 WAIT cycles; no rsp_vld_o; dp_x_o and dp_rnd_o read 0 afterward; the next request is served normally.
REQ-028 Reset mid-WAIT: rst_i for 1 cycle -> IDLE and all outputs 0 next cycle; ptr=0, so requester 0 wins the next simultaneous request.
